// File: rtl/img_frame_pkg.sv
// -----------------------------------------------------------------------------
// img_frame_pkg
// Shared definitions for the image frame receiver:
//   - FSM state encoding (localparams plus the state_t enum built from them)
//   - err_code values
//   - default start/end marker bytes
// Optional feature macro used by the importing files: IMG_CHECKSUM_EN.
// -----------------------------------------------------------------------------
package img_frame_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_GOT_S0 = 3'd1;
  localparam logic [2:0] ST_RECV   = 3'd2;
  localparam logic [2:0] ST_CHK    = 3'd3;
  localparam logic [2:0] ST_END_A  = 3'd4;
  localparam logic [2:0] ST_END_B  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_GOT_S0 = ST_GOT_S0,
    S_RECV   = ST_RECV,
    S_CHK    = ST_CHK,
    S_END_A  = ST_END_A,
    S_END_B  = ST_END_B
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_END     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CSUM    = 2'd3;

  localparam logic [7:0] DEF_START0 = 8'hBB;
  localparam logic [7:0] DEF_START1 = 8'h66;
  localparam logic [7:0] DEF_END0   = 8'h66;
  localparam logic [7:0] DEF_END1   = 8'hBB;

endpackage

// File: rtl/frame_timeout_counter.sv
// -----------------------------------------------------------------------------
// frame_timeout_counter
// Inter-byte gap watchdog. Counts clock cycles while enabled and not cleared;
// expire_o is high while the count sits at CYCLES-1 (and enable_i is high).
// The count holds at CYCLES-1 until cleared or disabled.
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   clear_i   restart the gap measurement (a byte arrived)
//   enable_i  measure only while high; count is held at 0 otherwise
//   expire_o  gap has reached CYCLES-1 cycles
// -----------------------------------------------------------------------------
module frame_timeout_counter #(
  parameter int unsigned CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear_i || !enable_i) begin
      cnt_q <= '0;
    end else if (cnt_q != LAST) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expire_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/image_frame_receiver.sv
// -----------------------------------------------------------------------------
// image_frame_receiver
// Frames the UART RX byte stream into the image RAM:
//   START0 START1, NUM_PIXELS pixel bytes, [checksum], END0 END1
// Framing is purely length based; pixel bytes equal to marker values are data.
// image_loaded falls when a new frame starts (START1) and rises only when a
// frame ends validly, so each good frame gives exactly one rising edge.
//
// Optional feature: define IMG_CHECKSUM_EN to require an 8-bit sum (mod 256)
// of the pixel bytes between the last pixel and END0 (err_code 3 on mismatch).
//
// Byte interface: rx_ready is a single-cycle strobe and rx_data is valid only
// in that cycle. There is no back-pressure; every strobe is consumed. Bytes are
// acted on only while weights_loaded is high.
//
// Ports:
//   clk, rst        100 MHz clock, asynchronous active-low reset
//   rx_data/rx_ready received byte and its strobe
//   weights_loaded  frames ignored (and an open frame silently dropped) while 0
//   wr_addr/wr_data/wr_en  image RAM write port, one cycle after the byte
//   image_loaded    level, complete valid frame in RAM
//   frame_error     one-cycle pulse on frame rejection
//   err_code        last rejection reason, held until next error or reset
//   busy            FSM is not in IDLE
//   dbg_state       raw FSM state for debug/checkers
// -----------------------------------------------------------------------------
module image_frame_receiver
  import img_frame_pkg::*;
#(
  parameter int unsigned NUM_PIXELS     = 784,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  START0         = DEF_START0,
  parameter logic [7:0]  START1         = DEF_START1,
  parameter logic [7:0]  END0           = DEF_END0,
  parameter logic [7:0]  END1           = DEF_END1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              weights_loaded,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_en,
  output logic              image_loaded,
  output logic              frame_error,
  output logic [1:0]        err_code,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] pix_cnt_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              wr_en_q;
  logic              image_loaded_q;
  logic              frame_error_q;
  logic [1:0]        err_code_q;
`ifdef IMG_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic tmo_expire;
  logic in_frame;

  assign in_frame = (state_q != S_IDLE);

  // Any strobe restarts the gap measurement, so a byte arriving in the same
  // cycle as expiry always wins over the timeout.
  frame_timeout_counter #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (rx_ready),
    .enable_i (in_frame),
    .expire_o (tmo_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      pix_cnt_q      <= '0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      wr_en_q        <= 1'b0;
      image_loaded_q <= 1'b0;
      frame_error_q  <= 1'b0;
      err_code_q     <= ERR_NONE;
`ifdef IMG_CHECKSUM_EN
      csum_q         <= '0;
`endif
    end else begin
      wr_en_q       <= 1'b0;
      frame_error_q <= 1'b0;

      if (in_frame && !weights_loaded) begin
        // Weights withdrawn mid-frame: drop the frame without reporting it.
        state_q <= S_IDLE;
      end else if (rx_ready && weights_loaded) begin
        unique case (state_q)
          S_IDLE: begin
            if (rx_data == START0) state_q <= S_GOT_S0;
          end
          S_GOT_S0: begin
            if (rx_data == START1) begin
              state_q        <= S_RECV;
              image_loaded_q <= 1'b0;
              pix_cnt_q      <= '0;
`ifdef IMG_CHECKSUM_EN
              csum_q         <= '0;
`endif
            end else if (rx_data != START0) begin
              // A repeated START0 keeps us here so BB BB 66 still syncs.
              state_q <= S_IDLE;
            end
          end
          S_RECV: begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= pix_cnt_q;
            wr_data_q <= rx_data;
            pix_cnt_q <= pix_cnt_q + ADDR_W'(1);
`ifdef IMG_CHECKSUM_EN
            csum_q    <= csum_q + rx_data;
            if (pix_cnt_q == LAST_PIX) state_q <= S_CHK;
`else
            if (pix_cnt_q == LAST_PIX) state_q <= S_END_A;
`endif
          end
`ifdef IMG_CHECKSUM_EN
          S_CHK: begin
            if (rx_data == csum_q) begin
              state_q <= S_END_A;
            end else begin
              frame_error_q <= 1'b1;
              err_code_q    <= ERR_CSUM;
              state_q       <= S_IDLE;
            end
          end
`endif
          S_END_A: begin
            if (rx_data == END0) begin
              state_q <= S_END_B;
            end else begin
              frame_error_q <= 1'b1;
              err_code_q    <= ERR_END;
              state_q       <= S_IDLE;
            end
          end
          S_END_B: begin
            if (rx_data == END1) begin
              image_loaded_q <= 1'b1;
            end else begin
              frame_error_q <= 1'b1;
              err_code_q    <= ERR_END;
            end
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (tmo_expire) begin
        // RAM is left partially written; image_loaded was already cleared
        // at START1 so it stays 0.
        frame_error_q <= 1'b1;
        err_code_q    <= ERR_TIMEOUT;
        state_q       <= S_IDLE;
      end
    end
  end

  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign wr_en        = wr_en_q;
  assign image_loaded = image_loaded_q;
  assign frame_error  = frame_error_q;
  assign err_code     = err_code_q;
  assign busy         = in_frame;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_image_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_image_frame_receiver
// Frame-level bench: frames are built from pixel patterns, their expected RAM
// writes and outcome are known from how each frame was constructed.
// Honours IMG_CHECKSUM_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_image_frame_receiver;

  localparam int NP  = 784;
  localparam int AW  = 10;
  localparam int TMO = 300;

  logic          clk;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          weights_loaded;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_en;
  logic          image_loaded;
  logic          frame_error;
  logic [1:0]    err_code;
  logic          busy;
  logic [2:0]    dbg_state;

  image_frame_receiver #(
    .NUM_PIXELS     (NP),
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .weights_loaded (weights_loaded),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .image_loaded   (image_loaded),
    .frame_error    (frame_error),
    .err_code       (err_code),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [AW+7:0] exp_q[$];
  logic [AW+7:0] got_q[$];
  logic [7:0]    pix [NP];
  int            total = 0;
  int            bad   = 0;
  int            n_pulse = 0;
  int            n_rise  = 0;
  logic          il_prev = 1'b0;

  always @(negedge clk) begin
    if (wr_en) got_q.push_back({wr_addr, wr_data});
    if (frame_error) n_pulse++;
    if (image_loaded && !il_prev) n_rise++;
    il_prev = image_loaded;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic check_writes(input string name);
    int nmis;
    nmis = 0;
    check({name, ".wr_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) nmis++;
    check({name, ".wr_content"}, nmis, 0);
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- frame construction ----------------
  task automatic build_pixels(input int pat);
    for (int i = 0; i < NP; i++) begin
      if (pat == 2) pix[i] = 8'($urandom_range(0, 255));
      else          pix[i] = 8'(i % 256);
    end
    if (pat == 1) begin
      pix[10] = 8'hBB; pix[11] = 8'h66; pix[12] = 8'h66; pix[13] = 8'hBB;
    end
  endtask

  function automatic logic [7:0] pix_sum();
    int s;
    s = 0;
    for (int i = 0; i < NP; i++) s += int'(pix[i]);
    return 8'(s % 256);
  endfunction

  // ---------------- drivers ----------------
  // Called at a negedge; returns at a later negedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_start(input bit dbl);
    if (dbl) send_byte(8'hBB, $urandom_range(0, 2));
    send_byte(8'hBB, $urandom_range(0, 2));
    send_byte(8'h66, 0);
  endtask

  task automatic send_pixels(input int first, input int count, input int max_gap, input bit rec);
    for (int i = first; i < first + count; i++) begin
      if (rec) exp_q.push_back({AW'(i), pix[i]});
      send_byte(pix[i], (i == first + count - 1) ? 0 : $urandom_range(0, max_gap));
    end
  endtask

  task automatic send_tail(input logic [7:0] e0, input logic [7:0] e1);
`ifdef IMG_CHECKSUM_EN
    send_byte(pix_sum(), $urandom_range(0, 2));
`endif
    send_byte(e0, $urandom_range(0, 2));
    send_byte(e1, 0);
  endtask

  task automatic run_frame(input string name, input int pat, input bit dbl,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input logic exp_loaded, input logic [1:0] exp_err,
                           input int exp_pulse);
    int p0, r0;
    p0 = n_pulse;
    r0 = n_rise;
    build_pixels(pat);
    send_start(dbl);
    check({name, ".loaded_clr"}, image_loaded, 0);
    send_pixels(0, NP, 2, 1'b1);
    send_tail(e0, e1);
    check({name, ".loaded_end"}, image_loaded, exp_loaded);
    repeat (3) @(negedge clk);
    check({name, ".busy"}, busy, 0);
    check({name, ".err_code"}, err_code, exp_err);
    check({name, ".err_pulses"}, n_pulse - p0, exp_pulse);
    check({name, ".rises"}, n_rise - r0, exp_loaded);
    check_writes(name);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         pat;
    bit         dbl;
    logic [7:0] e0;
    logic [7:0] e1;
    logic       exp_loaded;
    logic [1:0] exp_err;
    int         exp_pulse;
  } vec_t;

  vec_t vt[5];

  initial begin
    int p0, r0;
    logic [1:0] exp_err;
    logic [7:0] e0, e1;
    int kind;

    vt[0] = '{pat: 0, dbl: 1'b0, e0: 8'h66, e1: 8'hBB, exp_loaded: 1'b1, exp_err: 2'd0, exp_pulse: 0};
    vt[1] = '{pat: 1, dbl: 1'b1, e0: 8'h66, e1: 8'hBB, exp_loaded: 1'b1, exp_err: 2'd0, exp_pulse: 0};
    vt[2] = '{pat: 2, dbl: 1'b0, e0: 8'h66, e1: 8'h00, exp_loaded: 1'b0, exp_err: 2'd1, exp_pulse: 1};
    vt[3] = '{pat: 0, dbl: 1'b0, e0: 8'h00, e1: 8'h00, exp_loaded: 1'b0, exp_err: 2'd1, exp_pulse: 1};
    vt[4] = '{pat: 2, dbl: 1'b0, e0: 8'h66, e1: 8'hBB, exp_loaded: 1'b1, exp_err: 2'd1, exp_pulse: 0};

    // ---- reset ----
    rst = 1'b0; rx_data = 8'h00; rx_ready = 1'b0; weights_loaded = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.outputs", {wr_en, wr_addr, wr_data, image_loaded, frame_error, err_code, busy}, 0);
    check("reset.state", dbg_state, 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset.outputs", {wr_en, wr_addr, wr_data, image_loaded, frame_error, err_code, busy}, 0);

    // ---- gating: weights not loaded ----
    p0 = n_pulse;
    build_pixels(0);
    send_start(1'b0);
    send_pixels(0, NP, 1, 1'b0);
    send_tail(8'h66, 8'hBB);
    repeat (3) @(negedge clk);
    check("gate.loaded", image_loaded, 0);
    check("gate.busy", busy, 0);
    check("gate.pulses", n_pulse - p0, 0);
    check_writes("gate");

    // ---- table-driven frames ----
    weights_loaded = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++)
      run_frame($sformatf("vec%0d", k), vt[k].pat, vt[k].dbl, vt[k].e0, vt[k].e1,
                vt[k].exp_loaded, vt[k].exp_err, vt[k].exp_pulse);

    // ---- timeout after 100 pixels ----
    p0 = n_pulse;
    build_pixels(0);
    send_start(1'b0);
    send_pixels(0, 100, 0, 1'b1);
    repeat (TMO - 1) @(negedge clk);
    check("tmo.busy_before", busy, 1);
    @(negedge clk);
    check("tmo.busy_after", busy, 0);
    check("tmo.pulse", frame_error, 1);
    repeat (2) @(negedge clk);
    check("tmo.err_code", err_code, 2);
    check("tmo.loaded", image_loaded, 0);
    check("tmo.pulses", n_pulse - p0, 1);
    check_writes("tmo");
    run_frame("after_tmo", 0, 1'b0, 8'h66, 8'hBB, 1'b1, 2'd2, 0);

    // ---- byte arriving in the expiry cycle wins ----
    p0 = n_pulse; r0 = n_rise;
    build_pixels(2);
    send_start(1'b0);
    send_pixels(0, 50, 0, 1'b1);
    repeat (TMO - 1) @(negedge clk);
    send_pixels(50, NP - 50, 2, 1'b1);
    send_tail(8'h66, 8'hBB);
    repeat (3) @(negedge clk);
    check("edge_gap.loaded", image_loaded, 1);
    check("edge_gap.pulses", n_pulse - p0, 0);
    check("edge_gap.rises", n_rise - r0, 1);
    check_writes("edge_gap");

    // ---- weights withdrawn mid-frame ----
    p0 = n_pulse;
    build_pixels(0);
    send_start(1'b0);
    send_pixels(0, 30, 1, 1'b1);
    weights_loaded = 1'b0;
    @(negedge clk);
    check("wdrop.busy", busy, 0);
    weights_loaded = 1'b1;
    repeat (2) @(negedge clk);
    check("wdrop.pulses", n_pulse - p0, 0);
    check("wdrop.err_code", err_code, 2);
    check("wdrop.loaded", image_loaded, 0);
    check_writes("wdrop");

    // ---- START0 followed by a non-marker byte ----
    send_byte(8'hBB, 1);
    send_byte(8'h12, 1);
    send_byte(8'h66, 1);
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1);
    check("nosync.busy", busy, 0);
    check_writes("nosync");

`ifdef IMG_CHECKSUM_EN
    // ---- wrong checksum ----
    p0 = n_pulse;
    build_pixels(2);
    send_start(1'b0);
    send_pixels(0, NP, 1, 1'b1);
    send_byte(pix_sum() + 8'd1, 0);
    check("csum.pulse", frame_error, 1);
    repeat (2) @(negedge clk);
    check("csum.err_code", err_code, 3);
    check("csum.loaded", image_loaded, 0);
    check("csum.busy", busy, 0);
    check("csum.pulses", n_pulse - p0, 1);
    check_writes("csum");
`endif

    // ---- randomized frames ----
    exp_err = err_code;
    for (int k = 0; k < 3; k++) begin
      kind = $urandom_range(0, 2);
      e0 = 8'h66; e1 = 8'hBB;
      if (kind == 1) begin
        e1 = 8'($urandom_range(0, 255));
        if (e1 == 8'hBB) e1 = 8'h00;
      end else if (kind == 2) begin
        e0 = 8'($urandom_range(0, 255));
        if (e0 == 8'h66) e0 = 8'h11;
        e1 = 8'h00;
      end
      if (kind != 0) exp_err = 2'd1;
      run_frame($sformatf("rnd%0d", k), 2, 1'($urandom_range(0, 1)), e0, e1,
                (kind == 0), exp_err, (kind == 0) ? 0 : 1);
    end

    // ---- reset mid-frame ----
    build_pixels(0);
    send_start(1'b0);
    send_pixels(0, 20, 0, 1'b1);
    rx_data = 8'hA5;
    rst = 1'b0;
    #1;
    check("midreset.outputs", {wr_en, wr_addr, wr_data, image_loaded, frame_error, err_code, busy}, 0);
    @(negedge clk);
    rst = 1'b1;
    got_q.delete();
    exp_q.delete();
    @(negedge clk);
    run_frame("after_reset", 0, 1'b0, 8'h66, 8'hBB, 1'b1, 2'd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/image_frame_receiver.md
Name: image_frame_receiver

Overview:
- Upstream framing stage for the image RAM and inference path.
- Consumes the UART RX byte stream (`rx_data`/`rx_ready`) and detects a start marker.
- Writes exactly NUM_PIXELS bytes into the image RAM write port, then checks the end marker (and, optionally, a checksum).
- Raises `image_loaded`, whose rising edge the top level uses to start inference. Frames are accepted only after weights are loaded.

Parameters:
- NUM_PIXELS, 784, pixel bytes per frame
- ADDR_W, 10, image RAM address width
- TIMEOUT_CYCLES, 1000000, maximum inter-byte gap inside a frame (10 ms at 100 MHz)
- START0, 8'hBB, first start-marker byte
- START1, 8'h66, second start-marker byte
- END0, 8'h66, first end-marker byte
- END1, 8'hBB, second end-marker byte

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-low reset (0 = reset)
- rx_data  in  8  received UART byte
- rx_ready  in  1  one-cycle strobe; `rx_data` is valid in this cycle
- weights_loaded  in  1  level; frames are ignored while 0
- wr_addr  out  ADDR_W  image RAM write address
- wr_data  out  8  image RAM write data
- wr_en  out  1  image RAM write strobe
- image_loaded  out  1  level; 1 = complete valid frame in RAM
- frame_error  out  1  one-cycle pulse on frame rejection
- err_code  out  2  last error: 0 none, 1 bad end marker, 2 timeout, 3 checksum; held until the next error or reset
- busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; pixel counter 0; timeout counter 0.
- States: IDLE, GOT_S0, RECV, CHK (optional feature only), END_A, END_B.
- IDLE:
  - Byte accepted only when `rx_ready` && `weights_loaded`.
  - Byte == START0 -> GOT_S0.
- GOT_S0:
  - START1 -> RECV; `image_loaded` cleared to 0 in the same cycle; pixel counter reset to 0.
  - START0 -> stay in GOT_S0 (sequence BB BB 66 is valid).
  - Any other byte -> IDLE, no error.
- RECV:
  - Each byte is written with 1-cycle latency: the cycle after `rx_ready`, `wr_en`=1, `wr_addr`=counter, `wr_data`=byte.
  - Counter increments after each write.
  - After byte NUM_PIXELS-1 -> END_A (or CHK when the optional feature is compiled in).
  - Framing is length-based: pixel bytes equal to marker values are data, with no escaping.
- END_A:
  - byte == END0 -> END_B.
  - Otherwise: `frame_error`, `err_code`=1, -> IDLE.
- END_B:
  - byte == END1: `image_loaded`<=1 (stays 1 until the next START1 or reset), -> IDLE.
  - Otherwise: error code 1, -> IDLE.
- Timeout:
  - Counter runs in every non-IDLE state and clears on each `rx_ready`.
  - Reaching TIMEOUT_CYCLES-1 -> `frame_error`, `err_code`=2, -> IDLE.
  - RAM contents are left partial and `image_loaded` stays 0.
- `weights_loaded` falling mid-frame: silent abort to IDLE, no error, `image_loaded` unchanged.
- `wr_en` is never asserted outside RECV and never for address >= NUM_PIXELS.
- Simultaneous timeout expiry and `rx_ready`: the byte wins and the timeout is discarded.
- Reset mid-frame: immediate return to IDLE with all outputs 0.
- `image_loaded` falls at a new START1 and rises only at a valid end, so each valid frame produces exactly one rising edge.

Optional Feature:
- Macro: IMG_CHECKSUM_EN.
- Defined:
  - A running 8-bit sum (mod 256) of pixel bytes accumulates in RECV.
  - State CHK takes one extra byte after the last pixel.
  - Equal to the sum -> END_A.
  - Unequal -> `frame_error`, `err_code`=3, -> IDLE.
- Undefined:
  - No CHK state and no accumulator.
  - RECV goes straight to END_A.
  - `err_code`=3 is never produced.

Decomposition:
- Package img_frame_pkg holds:
  - state encoding localparams;
  - ERR_NONE/ERR_END/ERR_TIMEOUT/ERR_CSUM constants;
  - default marker byte values.
- One natural sub-module: frame_timeout_counter (clear input, enable input, expire output), reusable by weight_loader.
- The rest stays in a single FSM.

Test Plan:
- Valid frame: `weights_loaded`=1; send BB 66, pixels p[i]=i mod 256, then 66 BB.
  - Expect 784 writes with addr 0..783 and data = i mod 256.
  - Expect `image_loaded` 0->1 one cycle after the final BB; `err_code`=0.
- Pixels containing markers: pixels 10..13 = BB 66 66 BB.
  - Expect all 784 written and the frame accepted; no early termination.
- Bad end marker: frame ending 66 00.
  - Expect a `frame_error` pulse, `err_code`=1, `image_loaded`=0, `busy`=0.
- Timeout: send BB 66 plus 100 pixels, then silence for TIMEOUT_CYCLES.
  - Expect `frame_error`, `err_code`=2, 100 writes only.
  - A following complete frame is then accepted.
- Gating: `weights_loaded`=0 during a full frame -> no `wr_en`, `image_loaded`=0.
  - Then `weights_loaded`=1 with back-to-back frames: `image_loaded` drops at the second START1 and rises again at its end.
- IMG_CHECKSUM_EN defined:
  - Correct sum byte -> frame accepted.
  - Sum+1 -> `err_code`=3.
  - Reset asserted mid-frame -> all outputs 0 immediately.
